// File: rtl/alm_seq_ctrl.sv
// Sequencer for the shared truncated log converter of the ALM approximate multiplier.
// Converts A then B through one converter, adds the logs and applies a Mitchell antilog.
module alm_seq_ctrl #(
  parameter int M = 11
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [15:0]         in_a,
  input  logic [15:0]         in_b,
  output logic [15:0]         conv_o,
  output logic [15:0]         conv_x,
  input  logic [16-M+4-1:0]   conv_tlog,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         out_p,
  output logic                busy
);
  localparam int F = 16 - M;
  localparam int W = F + 4;

  typedef enum logic [2:0] {IDLE, CONV_A, CONV_B, SUM, OUT} state_t;

  state_t          state, state_nxt;
  logic [15:0]     a_reg, b_reg;
  logic            z;
  logic [W-1:0]    la, lb;
  logic [W:0]      lsum;
  logic [4:0]      k_sum;
  logic [F-1:0]    fr;
  logic [F+31:0]   shifted;
  logic [15:0]     cur_x;

  function automatic logic [15:0] msb_onehot(input logic [15:0] x);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 16; i++)
      if (x[i]) r = 16'(1) << i;
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_reg <= '0;
      b_reg <= '0;
      z     <= 1'b0;
      la    <= '0;
      lb    <= '0;
      out_p <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (in_valid) begin
          a_reg <= in_a;
          b_reg <= in_b;
          z     <= (in_a == 16'd0) | (in_b == 16'd0);
        end
        CONV_A: la <= conv_tlog;
        CONV_B: lb <= conv_tlog;
        SUM:    out_p <= z ? 32'd0 : shifted[F+31:F];
        default: ;
      endcase
    end
  end

  // Fraction carry naturally lands in the characteristic since K is the upper slice of the sum.
  always_comb begin
    lsum    = {1'b0, la} + {1'b0, lb};
    k_sum   = lsum[W:F];
    fr      = lsum[F-1:0];
    shifted = {31'd0, 1'b1, fr} << k_sum;
  end

  always_comb begin
    state_nxt = state;
    cur_x     = '0;
    case (state)
      IDLE:   if (in_valid) state_nxt = CONV_A;
      CONV_A: begin cur_x = a_reg; state_nxt = CONV_B; end
      CONV_B: begin cur_x = b_reg; state_nxt = SUM; end
      SUM:    state_nxt = OUT;
      OUT:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign conv_x    = cur_x;
  assign conv_o    = msb_onehot(cur_x);
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == OUT);
  assign busy      = (state != IDLE);
endmodule

// File: tb/tb_alm_seq_ctrl.sv
// Directed bench for alm_seq_ctrl with a behavioural truncated-log converter.
module tb_alm_seq_ctrl;
  localparam int M = 11;
  localparam int F = 16 - M;
  localparam int W = F + 4;

  logic clk = 0, rst = 1;
  logic in_valid = 0, in_ready, out_valid, out_ready = 1, busy;
  logic [15:0] in_a = 0, in_b = 0, conv_o, conv_x;
  logic [W-1:0] conv_tlog;
  logic [31:0] out_p;
  int total = 0, bad = 0;

  alm_seq_ctrl #(.M(M)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .conv_o(conv_o), .conv_x(conv_x),
    .conv_tlog(conv_tlog), .out_valid(out_valid), .out_ready(out_ready),
    .out_p(out_p), .busy(busy)
  );

  always #5 clk = ~clk;

  // converter model: k from the one-hot, y = top F bits below the leading one of x
  always_comb begin
    logic [3:0]  k;
    logic [15:0] n;
    k = 0;
    for (int i = 0; i < 16; i++) if (conv_o[i]) k = 4'(i);
    n = conv_x << (15 - k);
    conv_tlog = (conv_x == 0) ? '0 : {k, n[14 -: F]};
  end

  // Drives one transaction with out_ready=1; reports product, edges after acceptance
  // until out_valid, and converter signals observed in CONV_A/CONV_B.
  task automatic do_txn(input logic [15:0] a, input logic [15:0] b,
                        output logic [31:0] p, output int lat,
                        output logic [W-1:0] ta, output logic [W-1:0] tb,
                        output logic [15:0] oa, output logic [15:0] xa);
    @(negedge clk);
    in_valid = 1; in_a = a; in_b = b; out_ready = 1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 0;
    ta = conv_tlog; oa = conv_o; xa = conv_x;
    lat = 0; tb = '0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); @(negedge clk);
      lat++;
      if (lat == 1) tb = conv_tlog;
    end
    p = out_p;
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if ({in_ready, out_valid, busy} !== 3'b100 || out_p !== 0 || conv_o !== 0 || conv_x !== 0) begin
      bad++;
      $display("FAIL reset: rdy/vld/busy=%b out_p=%h conv_o=%h conv_x=%h want 100/0/0/0",
               {in_ready, out_valid, busy}, out_p, conv_o, conv_x);
    end
    rst = 0;
  endtask

  task automatic test_basic;
    logic [31:0] p; int lat; logic [W-1:0] ta, tb; logic [15:0] oa, xa;
    do_txn(16'd3, 16'd5, p, lat, ta, tb, oa, xa);
    total++; if (ta !== 9'h030) begin bad++; $display("FAIL tlog_a: got %h want 030", ta); end
    total++; if (tb !== 9'h048) begin bad++; $display("FAIL tlog_b: got %h want 048", tb); end
    total++; if (oa !== 16'h0002 || xa !== 16'd3) begin
      bad++; $display("FAIL conv_a: o=%h x=%h want 0002/0003", oa, xa); end
    total++; if (p !== 32'd14) begin bad++; $display("FAIL p_3x5: got %0d want 14", p); end
    // three edges after acceptance -> out_valid in cycle t+4
    total++; if (lat !== 3) begin bad++; $display("FAIL latency: got %0d want 3", lat); end
    total++; if (conv_o !== 0 || conv_x !== 0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL idle_after: o=%h x=%h rdy=%b", conv_o, conv_x, in_ready); end
    do_txn(16'hFFFF, 16'hFFFF, p, lat, ta, tb, oa, xa);
    total++; if (p !== 32'hF800_0000) begin bad++; $display("FAIL p_max: got %h want f8000000", p); end
    do_txn(16'd1, 16'd1, p, lat, ta, tb, oa, xa);
    total++; if (p !== 32'd1) begin bad++; $display("FAIL p_1x1: got %h want 1", p); end
    do_txn(16'h8000, 16'd2, p, lat, ta, tb, oa, xa);
    total++; if (p !== 32'h0001_0000) begin bad++; $display("FAIL p_8000x2: got %h want 10000", p); end
  endtask

  task automatic test_zero;
    logic [31:0] p; int lat; logic [W-1:0] ta, tb; logic [15:0] oa, xa;
    do_txn(16'd0, 16'd1234, p, lat, ta, tb, oa, xa);
    total++; if (p !== 0 || lat !== 3) begin
      bad++; $display("FAIL zero_a: p=%h lat=%0d want 0/3", p, lat); end
    do_txn(16'd1234, 16'd0, p, lat, ta, tb, oa, xa);
    total++; if (p !== 0 || lat !== 3) begin
      bad++; $display("FAIL zero_b: p=%h lat=%0d want 0/3", p, lat); end
  endtask

  task automatic test_backpressure;
    int n;
    @(negedge clk);
    in_valid = 1; in_a = 16'd3; in_b = 16'd5; out_ready = 0;
    @(posedge clk); @(negedge clk);
    in_a = 16'd7; in_b = 16'd9;  // keep in_valid high; must be ignored
    n = 0;
    while (!out_valid && n < 20) begin @(posedge clk); @(negedge clk); n++; end
    total++; if (!out_valid) begin bad++; $display("FAIL bp_timeout: out_valid never rose"); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk);
      total++;
      if (out_valid !== 1'b1 || out_p !== 32'd14 || in_ready !== 1'b0 || busy !== 1'b1) begin
        bad++; $display("FAIL bp_hold%0d: vld=%b p=%0d rdy=%b want 1/14/0", i, out_valid, out_p, in_ready);
      end
    end
    out_ready = 1;
    @(posedge clk); @(negedge clk);
    in_valid = 0;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL bp_release: vld=%b rdy=%b want 0/1", out_valid, in_ready); end
  endtask

  task automatic test_back_to_back;
    logic [15:0] pa [4] = '{16'd3, 16'd1, 16'h8000, 16'd7};
    logic [15:0] pb [4] = '{16'd5, 16'd1, 16'd2, 16'd9};
    logic [31:0] exp_p [4] = '{32'd14, 32'd1, 32'h0001_0000, 32'd60};
    int acc_cyc [4];
    logic [31:0] got [4];
    int acc = 0, outs = 0;
    out_ready = 1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      if (out_valid && outs < 4) begin got[outs] = out_p; outs++; end
      if (acc < 4) begin
        in_valid = 1; in_a = pa[acc]; in_b = pb[acc];
        if (in_ready) begin acc_cyc[acc] = cyc; acc++; end
      end else in_valid = 0;
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 0;
    total++; if (acc !== 4 || outs !== 4) begin
      bad++; $display("FAIL b2b_count: acc=%0d outs=%0d want 4/4", acc, outs); end
    for (int i = 0; i < 4 && i < outs; i++) begin
      total++; if (got[i] !== exp_p[i]) begin
        bad++; $display("FAIL b2b_p%0d: got %h want %h", i, got[i], exp_p[i]); end
    end
    for (int i = 1; i < 4 && i < acc; i++) begin
      total++; if (acc_cyc[i] - acc_cyc[i-1] !== 5) begin
        bad++; $display("FAIL b2b_gap%0d: got %0d want 5", i, acc_cyc[i] - acc_cyc[i-1]); end
    end
  endtask

  task automatic test_rst_mid;
    int seen = 0;
    @(negedge clk);
    in_valid = 1; in_a = 16'd3; in_b = 16'd5; out_ready = 1;
    @(posedge clk); @(negedge clk);   // CONV_A
    in_valid = 0;
    @(posedge clk); @(negedge clk);   // CONV_B
    total++; if (conv_x !== 16'd5) begin bad++; $display("FAIL rst_conv_b: conv_x=%h want 0005", conv_x); end
    rst = 1;
    @(posedge clk); @(negedge clk);
    rst = 0;
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL rst_mid: rdy=%b vld=%b busy=%b want 1/0/0", in_ready, out_valid, busy); end
    for (int i = 0; i < 8; i++) begin @(posedge clk); @(negedge clk); if (out_valid) seen++; end
    total++; if (seen !== 0) begin bad++; $display("FAIL rst_drop: %0d valid cycles want 0", seen); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_zero;
    test_backpressure;
    test_back_to_back;
    test_rst_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
